ex_muldiv_sequencer: RTL and testbench
======================================

Name: ex_muldiv_sequencer

Overview:
- Multi-cycle multiply/divide controller beside the execute stage.
- Replaces single-cycle MUL/DIV/REM arithmetic with an iterative shift-add multiplier and restoring divider, sequenced by an FSM.
- Accepts one request at a time via valid/ready and stalls EX through req_ready/busy.
- Result is held until the memory-stage side accepts it.

Parameters:
DATA_WIDTH, 64, operand/result width
WORD_WIDTH, 32, width used when is_word_op=1

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous active-low reset
req_valid  input  1  EX presents an operation
req_ready  output  1  sequencer can accept (state IDLE)
op  input  2  0=MUL (low product), 1=DIV, 2=REM, 3=reserved
signed_op  input  1  1=signed operands, 0=unsigned
is_word_op  input  1  operate on low WORD_WIDTH bits, sign-extend result
operand_a  input  DATA_WIDTH  multiplicand/dividend
operand_b  input  DATA_WIDTH  multiplier/divisor
dst_reg  input  5  destination register tag
flush  input  1  squash in-flight op (taken jump)
resp_valid  output  1  result available
resp_ready  input  1  consumer accepts result
result  output  DATA_WIDTH  product/quotient/remainder
resp_dst_reg  output  5  tag captured at accept
busy  output  1  high in any state except IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE; req_ready=1; resp_valid=0; busy=0; result=0; resp_dst_reg=0; counters/accumulators 0.
- States: IDLE, MUL_RUN, DIV_RUN, FIX, DONE.
- IDLE:
  - On req_valid&&req_ready (cycle T): capture op, signed_op, is_word_op, dst_reg.
  - Capture |operand_a| and |operand_b| when signed_op, else raw; word ops use low WORD_WIDTH bits only, signed ops sign-extended from bit 31.
  - Record result sign: MUL/DIV use a_sign^b_sign; REM uses a_sign.
  - Set N=WORD_WIDTH if is_word_op, else DATA_WIDTH.
  - op=0 -> MUL_RUN; op 1/2 -> DIV_RUN; op=3 -> FIX with raw result 0.
- MUL_RUN: one multiplier bit per cycle, LSB first; add shifted multiplicand when bit=1; exactly N cycles (T+1..T+N), then FIX. Low DATA_WIDTH bits kept (wrap modulo 2^DATA_WIDTH).
- DIV_RUN: restoring division, one quotient bit per cycle, MSB first; exactly N cycles, then FIX.
- FIX (cycle T+N+1):
  - Apply two's-complement negation per recorded sign.
  - Word ops: sign-extend bit 31 to DATA_WIDTH.
  - Drive result.
  - Go to DONE.
- DONE: resp_valid=1 from T+N+2. result and resp_dst_reg stay stable until resp_valid&&resp_ready, then return to IDLE. req_ready is 1 again the following cycle; there is no same-cycle back-to-back accept.
- Divide by zero: quotient = all ones (-1, sign-extended for word ops); remainder = dividend (original signed value). Sign fix is not applied to these values.
- Signed overflow (most-negative / -1, at active width): quotient = dividend, remainder = 0.
- flush:
  - Any non-IDLE state: go to IDLE next cycle, no resp_valid, result discarded.
  - IDLE: a flush in the same cycle as req_valid blocks the accept.
  - DONE: a flush in the same cycle as resp_ready still completes the handshake; flush wins only if resp_ready=0.
- Reset asserted mid-operation: immediate return to reset values; no partial result is ever output.
- busy=0 only in IDLE; EX stalls while req_valid&&!req_ready.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined:
  - From IDLE, MUL with either operand zero, DIV/REM with divisor zero, or signed overflow go directly to FIX with the final value; resp_valid at T+2.
  - MUL additionally exits MUL_RUN once the remaining multiplier bits are all zero.
- Undefined: every op takes the full N iterations; latency is fixed at N+2 cycles regardless of operand values.

Test Plan:
- MUL unsigned, a=7, b=6, 64-bit, resp_ready=1 -> result=42, resp_valid first at T+66 (early-out off), resp_dst_reg equals captured tag.
- DIV signed word, a=0xFFFF_FFFF_FFFF_FFF9 (-7), b=2 -> quotient 0xFFFF_FFFF_FFFF_FFFD (-3) at T+34; REM same operands -> 0xFFFF_FFFF_FFFF_FFFF (-1).
- DIV by zero, a=123, b=0 -> DIV result 0xFFFF_FFFF_FFFF_FFFF, REM result 123; with MULDIV_EARLY_OUT_EN, resp_valid at T+2.
- Signed overflow, a=0x8000_0000_0000_0000, b=-1 -> DIV returns 0x8000_0000_0000_0000, REM returns 0.
- Backpressure and flush: resp_ready=0 for 5 cycles holds result/resp_valid stable, then handshake -> req_ready=1 next cycle. flush at T+10 of a DIV -> IDLE at T+11, no resp_valid ever.
- Async reset low mid-MUL_RUN -> resp_valid=0, busy=0, req_ready=1 immediately; a new request after release completes correctly.

Source files
------------

// File: rtl/ex_muldiv_sequencer.sv
// Multi-cycle MUL/DIV/REM unit beside EX: shift-add multiplier and restoring divider under one FSM.
// Optional MULDIV_EARLY_OUT_EN: trivial operands skip iteration, multiplies stop when the multiplier runs out.
module ex_muldiv_sequencer #(
  parameter int DATA_WIDTH = 64,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            op,
  input  logic                  signed_op,
  input  logic                  is_word_op,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  input  logic [4:0]            dst_reg,
  input  logic                  flush,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic [4:0]            resp_dst_reg,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [1:0] OP_MUL = 2'd0;
  localparam logic [1:0] OP_DIV = 2'd1;
  localparam logic [1:0] OP_REM = 2'd2;

  typedef enum logic [2:0] {IDLE, MUL_RUN, DIV_RUN, FIX, DONE} state_t;

  state_t                state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic                  word_q, word_d;
  logic                  neg_q, neg_d;
  logic                  dbz_q, dbz_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] a_raw_q, a_raw_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] opa_q, opa_d;
  logic [DATA_WIDTH-1:0] opb_q, opb_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [4:0]            dst_q, dst_d;

  logic [DATA_WIDTH-1:0] a_ext, b_ext, a_mag, b_mag, min_val;
  logic                  a_neg, b_neg, dbz_in, ovf_in, accept;
  logic [DATA_WIDTH:0]   rem_shift, rem_diff;
  logic [DATA_WIDTH-1:0] raw, fixed;
  logic [CW-1:0]         last_cnt;

  // Operands at their active width, plus magnitudes for the unsigned datapath.
  always_comb begin
    if (is_word_op) begin
      a_ext   = {{(DATA_WIDTH-WORD_WIDTH){signed_op & operand_a[WORD_WIDTH-1]}}, operand_a[WORD_WIDTH-1:0]};
      b_ext   = {{(DATA_WIDTH-WORD_WIDTH){signed_op & operand_b[WORD_WIDTH-1]}}, operand_b[WORD_WIDTH-1:0]};
      min_val = {{(DATA_WIDTH-WORD_WIDTH+1){1'b1}}, {(WORD_WIDTH-1){1'b0}}};
    end else begin
      a_ext   = operand_a;
      b_ext   = operand_b;
      min_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end
    a_neg  = signed_op & a_ext[DATA_WIDTH-1];
    b_neg  = signed_op & b_ext[DATA_WIDTH-1];
    a_mag  = a_neg ? -a_ext : a_ext;
    b_mag  = b_neg ? -b_ext : b_ext;
    dbz_in = (b_ext == '0);
    ovf_in = signed_op && (b_ext == '1) && (a_ext == min_val);
    accept = req_valid && (state_q == IDLE) && !flush;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    word_d   = word_q;
    neg_d    = neg_q;
    dbz_d    = dbz_q;
    ovf_d    = ovf_q;
    a_raw_d  = a_raw_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    dst_d    = dst_q;
    rem_shift = {acc_q, opa_q[DATA_WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, opb_q};
    raw       = '0;
    fixed     = '0;
    last_cnt  = word_q ? CW'(WORD_WIDTH - 1) : CW'(DATA_WIDTH - 1);

    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = op;
          word_d  = is_word_op;
          dst_d   = dst_reg;
          neg_d   = (op == OP_REM) ? a_neg : (a_neg ^ b_neg);
          dbz_d   = dbz_in;
          ovf_d   = ovf_in;
          a_raw_d = a_ext;
          acc_d   = '0;
          cnt_d   = '0;
          opb_d   = b_mag;
          // Dividend is left-aligned so its MSB always leaves from the top bit.
          opa_d   = (op != OP_MUL && is_word_op) ? (a_mag << (DATA_WIDTH - WORD_WIDTH)) : a_mag;
          case (op)
            OP_MUL:         state_d = MUL_RUN;
            OP_DIV, OP_REM: state_d = DIV_RUN;
            default:        state_d = FIX;
          endcase
`ifdef MULDIV_EARLY_OUT_EN
          if ((op == OP_MUL && (a_ext == '0 || b_ext == '0)) ||
              ((op == OP_DIV || op == OP_REM) && (dbz_in || ovf_in)))
            state_d = FIX;
`endif
        end
      end
      MUL_RUN: begin
        if (opb_q[0]) acc_d = acc_q + opa_q;
        opa_d = opa_q << 1;
        opb_d = opb_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == last_cnt) state_d = FIX;
`ifdef MULDIV_EARLY_OUT_EN
        if (opb_q[DATA_WIDTH-1:1] == '0) state_d = FIX;
`endif
      end
      DIV_RUN: begin
        // Top bit of the difference is the borrow: clear means the divisor fits.
        if (!rem_diff[DATA_WIDTH]) begin
          acc_d = rem_diff[DATA_WIDTH-1:0];
          opa_d = {opa_q[DATA_WIDTH-2:0], 1'b1};
        end else begin
          acc_d = rem_shift[DATA_WIDTH-1:0];
          opa_d = {opa_q[DATA_WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == last_cnt) state_d = FIX;
      end
      FIX: begin
        case (op_q)
          OP_MUL, OP_REM: raw = acc_q;
          OP_DIV:         raw = opa_q;
          default:        raw = '0;
        endcase
        fixed = neg_q ? -raw : raw;
        if (op_q == OP_DIV || op_q == OP_REM) begin
          if (dbz_q)      fixed = (op_q == OP_DIV) ? '1 : a_raw_q;
          else if (ovf_q) fixed = (op_q == OP_DIV) ? a_raw_q : '0;
        end
        if (word_q) fixed = {{(DATA_WIDTH-WORD_WIDTH){fixed[WORD_WIDTH-1]}}, fixed[WORD_WIDTH-1:0]};
        result_d = fixed;
        state_d  = DONE;
      end
      DONE: begin
        if (resp_ready || flush) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A squashed op never reaches the result register.
    if (flush && (state_q == MUL_RUN || state_q == DIV_RUN || state_q == FIX)) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      word_q   <= 1'b0;
      neg_q    <= 1'b0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
      a_raw_q  <= '0;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      dst_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      word_q   <= word_d;
      neg_q    <= neg_d;
      dbz_q    <= dbz_d;
      ovf_q    <= ovf_d;
      a_raw_q  <= a_raw_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      dst_q    <= dst_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign resp_valid   = (state_q == DONE);
  assign result       = result_q;
  assign resp_dst_reg = dst_q;

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Bench for ex_muldiv_sequencer: arithmetic reference model checked every cycle plus literal pins.
module tb_ex_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  op = 2'd0;
  logic        signed_op = 1'b0;
  logic        is_word_op = 1'b0;
  logic [63:0] operand_a = '0;
  logic [63:0] operand_b = '0;
  logic [4:0]  dst_reg = '0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [63:0] result;
  logic [4:0]  resp_dst_reg;
  logic        busy;

  ex_muldiv_sequencer dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .op(op), .signed_op(signed_op), .is_word_op(is_word_op),
    .operand_a(operand_a), .operand_b(operand_b), .dst_reg(dst_reg),
    .flush(flush), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .result(result), .resp_dst_reg(resp_dst_reg), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference arithmetic straight from the operation definitions.
  function automatic logic [63:0] ref_result(input logic [1:0] o, input bit s, input bit w,
                                             input logic [63:0] a, input logic [63:0] b);
    logic [31:0] ua, ub, r32;
    logic [63:0] r;
    r = '0;
    r32 = '0;
    if (w) begin
      ua = a[31:0];
      ub = b[31:0];
      case (o)
        2'd0: r32 = ua * ub;
        2'd1: begin
          if (ub == 0) r32 = '1;
          else if (s && ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) r32 = ua;
          else if (s) r32 = $signed(ua) / $signed(ub);
          else r32 = ua / ub;
        end
        2'd2: begin
          if (ub == 0) r32 = ua;
          else if (s && ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) r32 = '0;
          else if (s) r32 = $signed(ua) % $signed(ub);
          else r32 = ua % ub;
        end
        default: r32 = '0;
      endcase
      r = {{32{r32[31]}}, r32};
    end else begin
      case (o)
        2'd0: r = a * b;
        2'd1: begin
          if (b == 0) r = '1;
          else if (s && a == 64'h8000_0000_0000_0000 && b == '1) r = a;
          else if (s) r = $signed(a) / $signed(b);
          else r = a / b;
        end
        2'd2: begin
          if (b == 0) r = a;
          else if (s && a == 64'h8000_0000_0000_0000 && b == '1) r = '0;
          else if (s) r = $signed(a) % $signed(b);
          else r = a % b;
        end
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  // Cycles from the accept cycle to the first cycle with resp_valid.
  function automatic int ref_latency(input logic [1:0] o, input bit s, input bit w,
                                     input logic [63:0] a, input logic [63:0] b);
    int n;
`ifdef MULDIV_EARLY_OUT_EN
    logic [63:0] ax, bx, bm, mn;
    int len;
`endif
    n = w ? 32 : 64;
    if (o == 2'd3) return 2;
`ifdef MULDIV_EARLY_OUT_EN
    ax = w ? (s ? {{32{a[31]}}, a[31:0]} : {32'd0, a[31:0]}) : a;
    bx = w ? (s ? {{32{b[31]}}, b[31:0]} : {32'd0, b[31:0]}) : b;
    mn = w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    if (o == 2'd0 && (ax == 0 || bx == 0)) return 2;
    if (o != 2'd0 && (bx == 0 || (s && bx == '1 && ax == mn))) return 2;
    if (o == 2'd0) begin
      bm = (s && bx[63]) ? -bx : bx;
      len = 0;
      for (int i = 0; i < 64; i++) if (bm[i]) len = i + 1;
      return len + 2;
    end
`endif
    return n + 2;
  endfunction

  // Transaction-level model of the unit's externally visible state.
  bit          m_busy = 1'b0;
  bit          m_valid = 1'b0;
  int          m_wait = 0;
  logic [63:0] m_res = '0;
  logic [4:0]  m_dst = '0;
  int          cyc = 0;
  int          acc_cycle = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_wait  <= 0;
    end else begin
      cyc <= cyc + 1;
      if (m_busy) begin
        if (flush || (m_valid && resp_ready)) begin
          m_busy  <= 1'b0;
          m_valid <= 1'b0;
        end else if (!m_valid) begin
          m_wait <= m_wait - 1;
          if (m_wait == 1) m_valid <= 1'b1;
        end
      end else if (req_valid && !flush) begin
        m_busy    <= 1'b1;
        m_wait    <= ref_latency(op, signed_op, is_word_op, operand_a, operand_b) - 1;
        m_res     <= ref_result(op, signed_op, is_word_op, operand_a, operand_b);
        m_dst     <= dst_reg;
        acc_cycle <= cyc;
      end
    end
  end

  logic [63:0] last_res = '0;
  logic [4:0]  last_dst = '0;
  int          last_lat = 0;
  bit          prev_valid = 1'b0;

  always @(negedge clk) begin
    chk("busy", busy, m_busy);
    chk("req_ready", req_ready, !m_busy);
    chk("resp_valid", resp_valid, m_valid);
    if (m_valid) begin
      chk("result", result, m_res);
      chk("resp_dst_reg", resp_dst_reg, m_dst);
    end
    if (!reset) begin
      chk("reset_result", result, 64'd0);
      chk("reset_dst", resp_dst_reg, 64'd0);
    end
    if (resp_valid && !prev_valid) begin
      last_res = result;
      last_dst = resp_dst_reg;
      last_lat = cyc - acc_cycle;
    end
    prev_valid = resp_valid;
  end

  task automatic present(input logic [1:0] o, input bit s, input bit w,
                         input logic [63:0] a, input logic [63:0] b, input logic [4:0] d);
    @(negedge clk);
    req_valid = 1'b1; op = o; signed_op = s; is_word_op = w;
    operand_a = a; operand_b = b; dst_reg = d;
    @(negedge clk);
    req_valid = 1'b0; operand_a = ~a; operand_b = ~b; dst_reg = ~d;
  endtask

  task automatic do_txn(input string name, input logic [1:0] o, input bit s, input bit w,
                        input logic [63:0] a, input logic [63:0] b, input logic [4:0] d,
                        input int hold, input logic [63:0] exp_res, input int exp_lat);
    int t;
    resp_ready = (hold == 0);
    present(o, s, w, a, b, d);
    t = 0;
    while (resp_valid !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_resp_seen"}, resp_valid, 1);
    @(posedge clk);
    #1;
    chk({name, "_res"}, last_res, exp_res);
    chk({name, "_dst"}, last_dst, d);
    if (exp_lat > 0) chk({name, "_lat"}, last_lat, exp_lat);
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      chk({name, "_hold_valid"}, resp_valid, 1);
      chk({name, "_hold_res"}, result, exp_res);
      resp_ready = 1'b1;
      @(negedge clk);
      chk({name, "_ready_after_hs"}, req_ready, 1);
    end
    $display("txn %s op=%0d s=%0d w=%0d a=%h b=%h -> result=%h dst=%0d latency=%0d",
             name, o, s, w, a, b, last_res, last_dst, last_lat);
  endtask

`ifdef MULDIV_EARLY_OUT_EN
  localparam int L_MUL76 = 5;
  localparam int L_DIV0  = 2;
`else
  localparam int L_MUL76 = 66;
  localparam int L_DIV0  = 66;
`endif

  initial begin
    int seen;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;

    do_txn("mul_7x6", 2'd0, 0, 0, 64'd7, 64'd6, 5'd5, 0, 64'd42, L_MUL76);
    do_txn("divw_m7_2", 2'd1, 1, 1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd7, 0, 64'hFFFF_FFFF_FFFF_FFFD, 34);
    do_txn("remw_m7_2", 2'd2, 1, 1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd8, 0, 64'hFFFF_FFFF_FFFF_FFFF, 34);
    do_txn("div_by0", 2'd1, 0, 0, 64'd123, 64'd0, 5'd10, 0, 64'hFFFF_FFFF_FFFF_FFFF, L_DIV0);
    do_txn("rem_by0", 2'd2, 0, 0, 64'd123, 64'd0, 5'd11, 0, 64'd123, L_DIV0);
    do_txn("div_ovf", 2'd1, 1, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd12, 0,
           64'h8000_0000_0000_0000, L_DIV0);
    do_txn("rem_ovf", 2'd2, 1, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd13, 0, 64'd0, L_DIV0);
    do_txn("mul_m3x5_hold", 2'd0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 5'd14, 5, 64'hFFFF_FFFF_FFFF_FFF1, 0);
    do_txn("mulw_m2x3", 2'd0, 1, 1, 64'h1234_5678_FFFF_FFFE, 64'hABCD_0000_0000_0003, 5'd15, 0,
           64'hFFFF_FFFF_FFFF_FFFA, 0);
    do_txn("divuw", 2'd1, 0, 1, 64'h0000_0000_FFFF_FFF0, 64'd16, 5'd16, 0, 64'h0000_0000_0FFF_FFFF, 34);
    do_txn("remu_100_7", 2'd2, 0, 0, 64'd100, 64'd7, 5'd17, 0, 64'd2, 66);
    do_txn("div_100_m7", 2'd1, 1, 0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 5'd18, 0, 64'hFFFF_FFFF_FFFF_FFF2, 66);
    do_txn("rem_m100_7", 2'd2, 1, 0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd19, 0, 64'hFFFF_FFFF_FFFF_FFFE, 66);
    do_txn("divw_ovf", 2'd1, 1, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd20, 0,
           64'hFFFF_FFFF_8000_0000, 0);
    do_txn("mul_wrap", 2'd0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd21, 0, 64'hFFFF_FFFF_FFFF_FFFE, 0);

    // Flush in IDLE blocks the accept.
    @(negedge clk);
    req_valid = 1'b1; flush = 1'b1; op = 2'd0; operand_a = 64'd3; operand_b = 64'd3;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    chk("flush_blocks_accept", busy, 0);

    // Flush at T+10 of a divide: idle at T+11, never a response.
    present(2'd1, 0, 0, 64'd1000, 64'd3, 5'd9);
    repeat (9) @(negedge clk);
    chk("div_busy_before_flush", busy, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_idle_busy", busy, 0);
    chk("flush_idle_ready", req_ready, 1);
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    chk("flush_no_resp", seen, 0);
    $display("txn flush_div squashed, resp_valid seen %0d times", seen);

    // Flush in DONE while the consumer stalls discards the result.
    resp_ready = 1'b0;
    present(2'd0, 0, 1, 64'd3, 64'd4, 5'd22);
    seen = 0;
    while (resp_valid !== 1'b1 && seen < 200) begin
      @(negedge clk);
      seen++;
    end
    chk("done_flush_resp_seen", resp_valid, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    resp_ready = 1'b1;
    chk("done_flush_valid", resp_valid, 0);
    chk("done_flush_busy", busy, 0);
    $display("txn flush_done dropped held result");

    // Asynchronous reset in the middle of a multiply.
    present(2'd0, 0, 0, 64'd99, 64'd77, 5'd23);
    repeat (20) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_req_ready", req_ready, 1);
    chk("arst_resp_valid", resp_valid, 0);
    chk("arst_result", result, 64'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    $display("txn reset_mid_mul aborted");
    do_txn("mul_after_rst", 2'd0, 0, 0, 64'h0000_0001_0000_0001, 64'h10, 5'd24, 0,
           64'h0000_0010_0000_0010, 0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, checks);
    $fatal(1, "watchdog");
  end

endmodule
